step_pulse_generator: RTL and testbench

Mode-driven step-pulse source for the fitness-tracker datapath. It emits single-cycle step pulses evenly spaced within each 1-second window, at a per-second rate chosen by a 2-bit activity mode. The hybrid mode plays a fixed 144-second rate profile. The block drives the pulse/rate inputs that the activity, distance and high-activity tracking blocks consume.

---
 rtl/step_pulse_generator.sv | 185 ++++++++++++++++++
 tb/tb_step_pulse_generator.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_generator.sv
// Mode-driven step-pulse source: evenly spaced one-cycle pulses per 1-second window,
// rate chosen by activity mode, with a fixed 144-second hybrid profile.
module step_pulse_generator #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] mode,
    output logic       pulse,
    output logic [7:0] rate,
    output logic       sec_tick,
    output logic [7:0] hyb_sec
);
    localparam int CW = $clog2(CLK_HZ);
    localparam int AW = CW + 1;
    localparam int SW = AW + 1;
    localparam logic [SW-1:0] CLK_S    = SW'(CLK_HZ);
    localparam logic [CW-1:0] CYC_LAST = CW'(CLK_HZ - 1);
    localparam logic [1:0]    MODE_HYB = 2'b11;
    localparam logic [7:0]    HYB_MAX  = 8'd145;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cyc, w_cyc_nxt;
    logic [AW-1:0] r_acc, w_acc_nxt;
    logic [1:0]    r_cur_mode, w_mode_nxt;
    logic [7:0]    r_rate, w_rate_nxt;
    logic [7:0]    r_hyb_sec, w_hyb_nxt;
    logic          r_pulse, w_pulse_nxt;
    logic          r_tick, w_tick_nxt;
    logic [SW-1:0] w_sum, w_sum_nxt;

    function automatic logic [7:0] base_rate(input logic [1:0] m);
        logic [7:0] r;
        case (m)
            2'b00:   r = 8'd32;
            2'b01:   r = 8'd64;
            2'b10:   r = 8'd128;
            default: r = 8'd0;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] hyb_rate(input logic [7:0] s);
        logic [7:0] r;
        case (s)
            8'd1:    r = 8'd20;
            8'd2:    r = 8'd33;
            8'd3:    r = 8'd66;
            8'd4:    r = 8'd27;
            8'd5:    r = 8'd70;
            8'd6:    r = 8'd30;
            8'd7:    r = 8'd19;
            8'd8:    r = 8'd30;
            8'd9:    r = 8'd33;
            default: begin
                if (s >= 8'd10 && s <= 8'd73) begin
                    r = 8'd69;
                end else if (s >= 8'd74 && s <= 8'd79) begin
                    r = 8'd34;
                end else if (s >= 8'd80 && s <= 8'd144) begin
                    r = 8'd124;
                end else begin
                    r = 8'd0;
                end
            end
        endcase
        return r;
    endfunction

    // Next-state logic; pulse/tick are computed one cycle ahead so the registered outputs line up with cyc
    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc;
        w_acc_nxt   = r_acc;
        w_mode_nxt  = r_cur_mode;
        w_rate_nxt  = r_rate;
        w_hyb_nxt   = r_hyb_sec;
        w_sum       = {1'b0, r_acc} + SW'(r_rate);
        w_sum_nxt   = '0;
        w_pulse_nxt = 1'b0;
        w_tick_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_cyc_nxt   = '0;
                    w_acc_nxt   = '0;
                    w_mode_nxt  = mode;
                    if (mode == MODE_HYB) begin
                        w_hyb_nxt  = 8'd1;
                        w_rate_nxt = hyb_rate(8'd1);
                    end else begin
                        w_hyb_nxt  = 8'd0;
                        w_rate_nxt = base_rate(mode);
                    end
                end else begin
                    w_cyc_nxt  = '0;
                    w_acc_nxt  = '0;
                    w_rate_nxt = 8'd0;
                    w_hyb_nxt  = 8'd0;
                end
            end
            S_RUN: begin
                if (!start) begin
                    w_state_nxt = S_IDLE;
                    w_cyc_nxt   = '0;
                    w_acc_nxt   = '0;
                    w_rate_nxt  = 8'd0;
                    w_hyb_nxt   = 8'd0;
                end else if (r_cyc == CYC_LAST) begin
                    w_cyc_nxt  = '0;
                    w_acc_nxt  = '0;
                    w_mode_nxt = mode;
                    if (mode != MODE_HYB) begin
                        w_hyb_nxt  = 8'd0;
                        w_rate_nxt = base_rate(mode);
                    end else begin
                        if (r_cur_mode != MODE_HYB) begin
                            w_hyb_nxt = 8'd1;
                        end else if (r_hyb_sec >= HYB_MAX) begin
                            w_hyb_nxt = HYB_MAX;
                        end else begin
                            w_hyb_nxt = r_hyb_sec + 8'd1;
                        end
                        w_rate_nxt = hyb_rate(w_hyb_nxt);
                    end
                end else begin
                    w_cyc_nxt = r_cyc + CW'(1);
                    if (w_sum >= CLK_S) begin
                        w_acc_nxt = AW'(w_sum - CLK_S);
                    end else begin
                        w_acc_nxt = AW'(w_sum);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cyc_nxt   = '0;
                w_acc_nxt   = '0;
                w_rate_nxt  = 8'd0;
                w_hyb_nxt   = 8'd0;
            end
        endcase
        if (w_state_nxt == S_RUN) begin
            w_sum_nxt   = {1'b0, w_acc_nxt} + SW'(w_rate_nxt);
            w_pulse_nxt = (w_sum_nxt >= CLK_S);
            w_tick_nxt  = (w_cyc_nxt == CYC_LAST);
        end else begin
            w_sum_nxt   = '0;
            w_pulse_nxt = 1'b0;
            w_tick_nxt  = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cyc      <= '0;
            r_acc      <= '0;
            r_cur_mode <= 2'b00;
            r_rate     <= 8'd0;
            r_hyb_sec  <= 8'd0;
            r_pulse    <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cyc      <= w_cyc_nxt;
            r_acc      <= w_acc_nxt;
            r_cur_mode <= w_mode_nxt;
            r_rate     <= w_rate_nxt;
            r_hyb_sec  <= w_hyb_nxt;
            r_pulse    <= w_pulse_nxt;
            r_tick     <= w_tick_nxt;
        end
    end

    assign pulse    = r_pulse;
    assign rate     = r_rate;
    assign sec_tick = r_tick;
    assign hyb_sec  = r_hyb_sec;
endmodule

// File: tb/tb_step_pulse_generator.sv
// Self-checking bench: dut_a at 1000 Hz for the timing scenarios, dut_h at 256 Hz to sweep the hybrid profile.
module tb_step_pulse_generator;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_a = 1'b0, start_h = 1'b0;
    logic [1:0] mode_a = 2'b00, mode_h = 2'b00;
    logic       pulse_a, pulse_h, tick_a, tick_h;
    logic [7:0] rate_a, rate_h, hyb_a, hyb_h;

    int n_chk = 0;
    int n_pass = 0;
    int cnt_a = 0, cnt_h = 0;
    int obs_a[$], obs_h[$];
    int exp_a[$], exp_h[$];

    step_pulse_generator #(.CLK_HZ(1000)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .mode(mode_a),
        .pulse(pulse_a), .rate(rate_a), .sec_tick(tick_a), .hyb_sec(hyb_a)
    );
    step_pulse_generator #(.CLK_HZ(256)) dut_h (
        .clk(clk), .reset(reset), .start(start_h), .mode(mode_h),
        .pulse(pulse_h), .rate(rate_h), .sec_tick(tick_h), .hyb_sec(hyb_h)
    );

    always #5 clk = ~clk;

    // Per-second pulse counts pushed on every sec_tick
    initial forever begin
        @(negedge clk);
        if (pulse_a) cnt_a++;
        if (tick_a) begin obs_a.push_back(cnt_a); cnt_a = 0; end
        if (pulse_h) cnt_h++;
        if (tick_h) begin obs_h.push_back(cnt_h); cnt_h = 0; end
    end

    function automatic int hyb_expect(input int s);
        case (s)
            1: return 20;  2: return 33;  3: return 66;  4: return 27;  5: return 70;
            6: return 30;  7: return 19;  8: return 30;  9: return 33;
            default: begin
                if (s >= 10 && s <= 73) return 69;
                if (s >= 74 && s <= 79) return 34;
                if (s >= 80 && s <= 144) return 124;
                return 0;
            end
        endcase
    endfunction

    task automatic wait_obs(input bit sel_h, input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            #1;
            if ((sel_h ? obs_h.size() : obs_a.size()) >= n) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic go_a(input logic [1:0] m);
        start_a = 1'b0;
        @(negedge clk); #1;
        obs_a.delete(); exp_a.delete(); cnt_a = 0;
        mode_a = m; start_a = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int guard;
        bit ok;
        int e, o;
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        n_chk++;
        if ({pulse_a, rate_a, tick_a, hyb_a} !== 18'd0)
            $display("FAIL reset_state got p=%0b r=%0d t=%0b h=%0d expected all 0", pulse_a, rate_a, tick_a, hyb_a);
        else n_pass++;
        reset = 1'b0;
        go_a(2'b10);
        for (int i = 0; i < 300; i++) @(negedge clk);
        guard = 0;
        while (!pulse_a && guard < 50) begin @(negedge clk); guard++; end
        n_chk++;
        if (pulse_a !== 1'b1) $display("FAIL reset_prepulse got pulse=%0b expected 1", pulse_a);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_chk++;
        if ({pulse_a, rate_a, tick_a, hyb_a} !== 18'd0)
            $display("FAIL reset_async got p=%0b r=%0d t=%0b h=%0d expected all 0", pulse_a, rate_a, tick_a, hyb_a);
        else n_pass++;
        obs_a.delete(); exp_a.delete(); cnt_a = 0;
        @(negedge clk);
        n_chk++;
        if (rate_a !== 8'd0) $display("FAIL reset_wins got rate=%0d expected 0", rate_a);
        else n_pass++;
        exp_a.push_back(128);
        reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if (rate_a !== 8'd128) $display("FAIL reset_restart_rate got %0d expected 128", rate_a);
        else n_pass++;
        wait_obs(1'b0, 1, 1100, ok);
        if (!ok) begin n_chk++; $display("FAIL reset_timeout got no sec_tick expected one"); end
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            o = -1;
            if (obs_a.size() > 0) o = obs_a.pop_front();
            n_chk++;
            if (o !== e) $display("FAIL reset_count got %0d expected %0d", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_walk();
        int first, last, ticks, e, o;
        bit ok;
        go_a(2'b00);
        exp_a.push_back(32); exp_a.push_back(32);
        first = -1; last = -1; ticks = 0;
        n_chk++;
        if (rate_a !== 8'd32) $display("FAIL walk_rate got %0d expected 32", rate_a);
        else n_pass++;
        for (int i = 0; i < 2000; i++) begin
            if (pulse_a) begin
                if (first < 0) first = i;
                else begin
                    n_chk++;
                    if ((i - last) != 31 && (i - last) != 32)
                        $display("FAIL walk_spacing got %0d expected 31 or 32", i - last);
                    else n_pass++;
                end
                last = i;
            end
            if (tick_a) begin
                ticks++;
                n_chk++;
                if ((i % 1000) != 999) $display("FAIL walk_tick_pos got %0d expected 999", i % 1000);
                else n_pass++;
            end
            @(negedge clk);
        end
        n_chk++;
        if (first != 31) $display("FAIL walk_first got %0d expected 31", first);
        else n_pass++;
        n_chk++;
        if (ticks != 2) $display("FAIL walk_ticks got %0d expected 2", ticks);
        else n_pass++;
        wait_obs(1'b0, 2, 100, ok);
        if (!ok) begin n_chk++; $display("FAIL walk_timeout got %0d seconds expected 2", obs_a.size()); end
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            o = -1;
            if (obs_a.size() > 0) o = obs_a.pop_front();
            n_chk++;
            if (o !== e) $display("FAIL walk_count got %0d expected %0d", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_mode_change();
        int e, o;
        bit ok;
        go_a(2'b00);
        exp_a.push_back(32); exp_a.push_back(128);
        for (int i = 0; i < 2000; i++) begin
            if (i == 500) mode_a = 2'b10;
            if (i == 999) begin
                n_chk++;
                if (rate_a !== 8'd32 || tick_a !== 1'b1)
                    $display("FAIL mode_last got rate=%0d tick=%0b expected 32/1", rate_a, tick_a);
                else n_pass++;
            end
            if (i == 1000) begin
                n_chk++;
                if (rate_a !== 8'd128) $display("FAIL mode_new_rate got %0d expected 128", rate_a);
                else n_pass++;
            end
            @(negedge clk);
        end
        wait_obs(1'b0, 2, 100, ok);
        if (!ok) begin n_chk++; $display("FAIL mode_timeout got %0d seconds expected 2", obs_a.size()); end
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            o = -1;
            if (obs_a.size() > 0) o = obs_a.pop_front();
            n_chk++;
            if (o !== e) $display("FAIL mode_count got %0d expected %0d", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_jog_boundary();
        int e, o;
        bit ok;
        go_a(2'b01);
        for (int s = 0; s < 3; s++) exp_a.push_back(64);
        for (int i = 0; i <= 3000; i++) begin
            if ((i % 1000) == 0) begin
                n_chk++;
                if (dut_a.r_acc !== '0) $display("FAIL jog_acc got %0d expected 0", dut_a.r_acc);
                else n_pass++;
            end
            if (i < 3000) @(negedge clk);
        end
        wait_obs(1'b0, 3, 100, ok);
        if (!ok) begin n_chk++; $display("FAIL jog_timeout got %0d seconds expected 3", obs_a.size()); end
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            o = -1;
            if (obs_a.size() > 0) o = obs_a.pop_front();
            n_chk++;
            if (o !== e) $display("FAIL jog_count got %0d expected %0d", o, e);
            else n_pass++;
        end
    endtask

    task automatic test_stop_restart();
        int seen, e, o;
        bit ok;
        go_a(2'b11);
        for (int s = 1; s <= 4; s++) exp_a.push_back(hyb_expect(s));
        for (int i = 0; i < 4400; i++) @(negedge clk);
        n_chk++;
        if (hyb_a !== 8'd5) $display("FAIL stop_sec got %0d expected 5", hyb_a);
        else n_pass++;
        start_a = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({pulse_a, rate_a, tick_a, hyb_a} !== 18'd0)
            $display("FAIL stop_outputs got p=%0b r=%0d t=%0b h=%0d expected all 0", pulse_a, rate_a, tick_a, hyb_a);
        else n_pass++;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (pulse_a) seen++;
            @(negedge clk);
        end
        n_chk++;
        if (seen != 0) $display("FAIL stop_quiet got %0d pulses expected 0", seen);
        else n_pass++;
        wait_obs(1'b0, 4, 10, ok);
        if (!ok) begin n_chk++; $display("FAIL stop_timeout got %0d seconds expected 4", obs_a.size()); end
        while (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            o = -1;
            if (obs_a.size() > 0) o = obs_a.pop_front();
            n_chk++;
            if (o !== e) $display("FAIL stop_count got %0d expected %0d", o, e);
            else n_pass++;
        end
        start_a = 1'b1;
        @(negedge clk);
        n_chk++;
        if (hyb_a !== 8'd1 || rate_a !== 8'd20)
            $display("FAIL restart got hyb=%0d rate=%0d expected 1/20", hyb_a, rate_a);
        else n_pass++;
        start_a = 1'b0;
    endtask

    task automatic test_hybrid();
        int e, o;
        bit ok;
        start_h = 1'b0;
        @(negedge clk); #1;
        obs_h.delete(); exp_h.delete(); cnt_h = 0;
        mode_h = 2'b11; start_h = 1'b1;
        for (int s = 1; s <= 150; s++) exp_h.push_back(hyb_expect(s));
        @(negedge clk);
        wait_obs(1'b1, 150, 256 * 152, ok);
        if (!ok) begin n_chk++; $display("FAIL hyb_timeout got %0d seconds expected 150", obs_h.size()); end
        for (int s = 1; exp_h.size() > 0; s++) begin
            e = exp_h.pop_front();
            o = -1;
            if (obs_h.size() > 0) o = obs_h.pop_front();
            n_chk++;
            if (o !== e) $display("FAIL hyb_count_s%0d got %0d expected %0d", s, o, e);
            else n_pass++;
        end
        n_chk++;
        if (hyb_h !== 8'd145 || rate_h !== 8'd0)
            $display("FAIL hyb_saturate got hyb=%0d rate=%0d expected 145/0", hyb_h, rate_h);
        else n_pass++;
        start_h = 1'b0;
    endtask

    initial begin
        test_reset();
        test_walk();
        test_mode_change();
        test_jog_boundary();
        test_stop_restart();
        test_hybrid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
